// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular in-order retirement buffer with rename tags, operand bypass and mispredict flush.
// Optional feature macro ROB_PERF_EN builds the commit/flush performance counters.
module reorder_buffer #(
    parameter int ROB_SIZE_LOG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    output logic                    full,
    input  logic                    issue,
    output logic [ROB_SIZE_LOG-1:0] issue_rob_pos,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_has_rd,
    input  logic                    issue_ready,
    input  logic [31:0]             issue_val,
    input  logic                    issue_is_store,
    input  logic                    issue_is_br,
    input  logic                    issue_pred_taken,
    input  logic [31:0]             issue_pc,
    input  logic                    alu_result,
    input  logic [ROB_SIZE_LOG-1:0] alu_rob_pos,
    input  logic [31:0]             alu_val,
    input  logic                    alu_br_taken,
    input  logic [31:0]             alu_br_target,
    input  logic                    lsb_result,
    input  logic [ROB_SIZE_LOG-1:0] lsb_rob_pos,
    input  logic [31:0]             lsb_val,
    input  logic [ROB_SIZE_LOG-1:0] rs1_rob_pos,
    input  logic [ROB_SIZE_LOG-1:0] rs2_rob_pos,
    output logic                    rs1_ready,
    output logic [31:0]             rs1_val,
    output logic                    rs2_ready,
    output logic [31:0]             rs2_val,
    output logic                    commit,
    output logic [4:0]              commit_rd,
    output logic [31:0]             commit_val,
    output logic [ROB_SIZE_LOG-1:0] commit_rob_pos,
    output logic                    commit_store,
    output logic                    rollback,
    output logic [31:0]             rollback_pc,
    output logic [31:0]             perf_commit_cnt,
    output logic [31:0]             perf_flush_cnt
);
    localparam int N = 1 << ROB_SIZE_LOG;
    localparam int CW = ROB_SIZE_LOG + 1;
    typedef logic [ROB_SIZE_LOG-1:0] pos_t;

    pos_t          head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic [N-1:0]  busy_reg, ready_reg;
    logic [N-1:0]  has_rd_reg, is_store_reg, is_br_reg, pred_taken_reg, br_taken_reg;
    logic [4:0]    rd_reg        [N];
    logic [31:0]   val_reg       [N];
    logic [31:0]   br_target_reg [N];
    logic [31:0]   pc_reg        [N];

    logic         accept, issue_fire, retire_fire, mispredict, flush;
    logic [N-1:0] alu_hit, lsb_hit, issue_hit, retire_hit;

    assign full          = (count_reg == CW'(N));
    assign issue_rob_pos = tail_reg;
    // The registered rollback pulse marks the cycle upstream spends flushing.
    assign accept      = rdy && !rollback;
    assign issue_fire  = accept && issue && !full;
    assign retire_fire = accept && (count_reg != '0) && ready_reg[head_reg];
    assign mispredict  = is_br_reg[head_reg] && (br_taken_reg[head_reg] != pred_taken_reg[head_reg]);
    assign flush       = retire_fire && mispredict;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_hit
            assign alu_hit[gi]    = !rollback && alu_result && (alu_rob_pos == pos_t'(gi)) && busy_reg[gi];
            assign lsb_hit[gi]    = !rollback && lsb_result && (lsb_rob_pos == pos_t'(gi)) && busy_reg[gi];
            assign issue_hit[gi]  = issue_fire && (tail_reg == pos_t'(gi));
            assign retire_hit[gi] = retire_fire && (head_reg == pos_t'(gi));
        end
    endgenerate

    always_comb begin
        rs1_ready = ready_reg[rs1_rob_pos] | alu_hit[rs1_rob_pos] | lsb_hit[rs1_rob_pos];
        rs1_val   = alu_hit[rs1_rob_pos] ? alu_val :
                    lsb_hit[rs1_rob_pos] ? lsb_val : val_reg[rs1_rob_pos];
        rs2_ready = ready_reg[rs2_rob_pos] | alu_hit[rs2_rob_pos] | lsb_hit[rs2_rob_pos];
        rs2_val   = alu_hit[rs2_rob_pos] ? alu_val :
                    lsb_hit[rs2_rob_pos] ? lsb_val : val_reg[rs2_rob_pos];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            busy_reg  <= '0;
            ready_reg <= '0;
        end else if (rdy) begin
            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
                busy_reg  <= '0;
                ready_reg <= '0;
            end else begin
                if (issue_fire)  tail_reg <= tail_reg + pos_t'(1);
                if (retire_fire) head_reg <= head_reg + pos_t'(1);
                count_reg <= count_reg + CW'(issue_fire) - CW'(retire_fire);
                for (int i = 0; i < N; i++) begin
                    if (issue_hit[i]) begin
                        busy_reg[i]  <= 1'b1;
                        ready_reg[i] <= issue_ready;
                    end else if (retire_hit[i]) begin
                        busy_reg[i]  <= 1'b0;
                        ready_reg[i] <= 1'b0;
                    end else if (alu_hit[i] || lsb_hit[i]) begin
                        ready_reg[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Payload needs no reset: it is only observed through busy/ready.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < N; i++) begin
                if (issue_hit[i]) begin
                    rd_reg[i]         <= issue_rd;
                    has_rd_reg[i]     <= issue_has_rd;
                    val_reg[i]        <= issue_val;
                    is_store_reg[i]   <= issue_is_store;
                    is_br_reg[i]      <= issue_is_br;
                    pred_taken_reg[i] <= issue_pred_taken;
                    br_taken_reg[i]   <= 1'b0;
                    br_target_reg[i]  <= '0;
                    pc_reg[i]         <= issue_pc;
                end else if (!retire_hit[i]) begin
                    if (alu_hit[i]) begin
                        val_reg[i]       <= alu_val;
                        br_taken_reg[i]  <= alu_br_taken;
                        br_target_reg[i] <= alu_br_target;
                    end else if (lsb_hit[i]) begin
                        val_reg[i] <= lsb_val;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit         <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_rob_pos <= '0;
            commit_store   <= 1'b0;
            rollback       <= 1'b0;
            rollback_pc    <= '0;
        end else if (!rdy) begin
            commit       <= 1'b0;
            commit_store <= 1'b0;
            rollback     <= 1'b0;
        end else begin
            commit       <= retire_fire && has_rd_reg[head_reg];
            commit_store <= retire_fire && is_store_reg[head_reg];
            rollback     <= flush;
            if (retire_fire) begin
                commit_rd      <= rd_reg[head_reg];
                commit_val     <= val_reg[head_reg];
                commit_rob_pos <= head_reg;
            end
            if (flush)
                rollback_pc <= br_taken_reg[head_reg] ? br_target_reg[head_reg]
                                                      : pc_reg[head_reg] + 32'd4;
        end
    end

`ifdef ROB_PERF_EN
    logic [31:0] perf_commit_reg, perf_flush_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_commit_reg <= '0;
            perf_flush_reg  <= '0;
        end else if (rdy) begin
            if (retire_fire) perf_commit_reg <= perf_commit_reg + 32'd1;
            if (flush)       perf_flush_reg  <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_commit_cnt = perf_commit_reg;
    assign perf_flush_cnt  = perf_flush_reg;
`else
    assign perf_commit_cnt = '0;
    assign perf_flush_cnt  = '0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed test-plan steps plus random traffic checked against a program-order queue model.
module tb_reorder_buffer;
    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
    logic        full, issue = 1'b0;
    logic [3:0]  issue_rob_pos;
    logic [4:0]  issue_rd = '0;
    logic        issue_has_rd = 1'b0, issue_ready = 1'b0, issue_is_store = 1'b0;
    logic        issue_is_br = 1'b0, issue_pred_taken = 1'b0;
    logic [31:0] issue_val = '0, issue_pc = '0;
    logic        alu_result = 1'b0, alu_br_taken = 1'b0;
    logic [3:0]  alu_rob_pos = '0;
    logic [31:0] alu_val = '0, alu_br_target = '0;
    logic        lsb_result = 1'b0;
    logic [3:0]  lsb_rob_pos = '0;
    logic [31:0] lsb_val = '0;
    logic [3:0]  rs1_rob_pos = '0, rs2_rob_pos = '0;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_val, rs2_val;
    logic        commit, commit_store, rollback;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val, rollback_pc, perf_commit_cnt, perf_flush_cnt;
    logic [3:0]  commit_rob_pos;

    reorder_buffer dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .full(full), .issue(issue),
        .issue_rob_pos(issue_rob_pos), .issue_rd(issue_rd), .issue_has_rd(issue_has_rd),
        .issue_ready(issue_ready), .issue_val(issue_val), .issue_is_store(issue_is_store),
        .issue_is_br(issue_is_br), .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
        .alu_result(alu_result), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val),
        .alu_br_taken(alu_br_taken), .alu_br_target(alu_br_target),
        .lsb_result(lsb_result), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
        .rs1_rob_pos(rs1_rob_pos), .rs2_rob_pos(rs2_rob_pos),
        .rs1_ready(rs1_ready), .rs1_val(rs1_val), .rs2_ready(rs2_ready), .rs2_val(rs2_val),
        .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_pos(commit_rob_pos), .commit_store(commit_store),
        .rollback(rollback), .rollback_pc(rollback_pc),
        .perf_commit_cnt(perf_commit_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        has_rd, ready, is_store, is_br, pred, taken;
        logic [31:0] val, target, pc;
    } ent_t;

    // Model: in-flight instructions in program order; tag of q[i] is (head+i) mod 16.
    ent_t        q[$];
    int          head = 0;
    logic        m_rb = 1'b0, e_commit = 1'b0, e_store = 1'b0, e_ret = 1'b0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_val = '0, e_rbpc = '0;
    int          e_pos = 0, n_commit = 0, n_flush = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head = 0; m_rb = 1'b0; e_ret = 1'b0; e_commit = 1'b0; e_store = 1'b0;
        n_commit = 0; n_flush = 0;
    endtask

    function automatic int idx_of(input logic [3:0] t);
        return (int'(t) - head + 16) % 16;
    endfunction

    task automatic query_check(input string tag, input logic [3:0] t, input logic obs_r, input logic [31:0] obs_v);
        int i = idx_of(t);
        logic er = 1'b0;
        logic [31:0] ev = '0;
        if (i < q.size() && !m_rb) begin
            if (alu_result && alu_rob_pos == t)      begin er = 1'b1; ev = alu_val; end
            else if (lsb_result && lsb_rob_pos == t) begin er = 1'b1; ev = lsb_val; end
            else if (q[i].ready)                     begin er = 1'b1; ev = q[i].val; end
        end
        chk({tag, "_ready"}, 32'(obs_r), 32'(er));
        if (er) chk({tag, "_val"}, obs_v, ev);
    endtask

    task automatic model_edge();
        int n = q.size();
        int ai, li;
        ent_t e, ne;
        e_commit = 1'b0; e_store = 1'b0; e_ret = 1'b0;
        if (!rdy) begin m_rb = 1'b0; return; end
        if (!m_rb) begin
            e_ret = (n > 0) && q[0].ready;
            ai = idx_of(alu_rob_pos);
            li = idx_of(lsb_rob_pos);
            if (lsb_result && li < n && !(e_ret && li == 0)) q[li].val = lsb_val;
            if (alu_result && ai < n && !(e_ret && ai == 0)) begin
                q[ai].val = alu_val; q[ai].taken = alu_br_taken; q[ai].target = alu_br_target;
            end
            if (e_ret) begin
                e = q[0];
                e_commit = e.has_rd; e_store = e.is_store;
                e_rd = e.rd; e_val = e.val; e_pos = head;
                n_commit++;
                if (e.is_br && e.taken != e.pred) begin
                    e_rbpc = e.taken ? e.target : e.pc + 32'd4;
                    q.delete(); head = 0; n_flush++;
                    m_rb = 1'b1;
                    $display("retire pos=%0d val=%h flush pc=%h", e_pos, e_val, e_rbpc);
                    return;
                end
                void'(q.pop_front());
                head = (head + 1) % 16;
                $display("retire pos=%0d rd=%0d val=%h commit=%0b store=%0b", e_pos, e_rd, e_val, e_commit, e_store);
            end
            if (issue && n < 16) begin
                ne.rd = issue_rd; ne.has_rd = issue_has_rd; ne.ready = issue_ready; ne.val = issue_val;
                ne.is_store = issue_is_store; ne.is_br = issue_is_br; ne.pred = issue_pred_taken;
                ne.taken = 1'b0; ne.target = '0; ne.pc = issue_pc;
                q.push_back(ne);
            end
            if (alu_result && ai < n && !(e_ret && ai == 0)) q[ai - (e_ret ? 1 : 0)].ready = 1'b1;
            if (lsb_result && li < n && !(e_ret && li == 0)) q[li - (e_ret ? 1 : 0)].ready = 1'b1;
        end
        m_rb = 1'b0;
    endtask

    // One clock: combinational checks, active edge, model update, registered checks.
    task automatic cyc();
        #1;
        chk("full", 32'(full), 32'(q.size() == 16));
        chk("issue_rob_pos", 32'(issue_rob_pos), 32'((head + q.size()) % 16));
        query_check("rs1", rs1_rob_pos, rs1_ready, rs1_val);
        query_check("rs2", rs2_rob_pos, rs2_ready, rs2_val);
        @(posedge clk);
        model_edge();
        #1;
        chk("commit", 32'(commit), 32'(e_commit));
        chk("commit_store", 32'(commit_store), 32'(e_store));
        chk("rollback", 32'(rollback), 32'(m_rb));
        if (e_commit) begin
            chk("commit_rd", 32'(commit_rd), 32'(e_rd));
            chk("commit_val", commit_val, e_val);
        end
        if (e_ret) chk("commit_rob_pos", 32'(commit_rob_pos), 32'(e_pos));
        if (m_rb)  chk("rollback_pc", rollback_pc, e_rbpc);
`ifdef ROB_PERF_EN
        chk("perf_commit", perf_commit_cnt, 32'(n_commit));
        chk("perf_flush", perf_flush_cnt, 32'(n_flush));
`else
        chk("perf_commit_tied", perf_commit_cnt, 32'd0);
        chk("perf_flush_tied", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
    endtask

    task automatic idle();
        rdy = 1'b1; issue = 1'b0; alu_result = 1'b0; lsb_result = 1'b0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic has_rd, input logic rdyv, input logic [31:0] v,
                             input logic st, input logic br, input logic pred, input logic [31:0] pc);
        issue = 1'b1; issue_rd = rd; issue_has_rd = has_rd; issue_ready = rdyv; issue_val = v;
        issue_is_store = st; issue_is_br = br; issue_pred_taken = pred; issue_pc = pc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #1;
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_rollback", 32'(rollback), 32'd0);
        chk("rst_rollback_pc", rollback_pc, 32'd0);
        chk("rst_commit_val", commit_val, 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_issue_pos", 32'(issue_rob_pos), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cand[$];
        int k;
        @(negedge clk);
        do_reset();
        cyc();

        // Ready-at-issue instruction commits two cycles later.
        set_issue(5'd5, 1'b1, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("t1_issue_pos", 32'(issue_rob_pos), 32'd0);
        cyc();
        idle(); cyc();
        chk("t1_commit_val", commit_val, 32'h1234);
        cyc();

        // Fill to 16, blocked 17th issue, then wrap after one retirement.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(5'(i + 1), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'(i * 4));
            cyc();
        end
        set_issue(5'd31, 1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("t2_full", 32'(full), 32'd1);
        cyc();
        idle(); alu_result = 1'b1; alu_rob_pos = 4'd0; alu_val = 32'h55; cyc();
        idle(); cyc();
        chk("t2_commit_pos", 32'(commit_rob_pos), 32'd0);
        set_issue(5'd9, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("t2_wrap_pos", 32'(issue_rob_pos), 32'd0);
        cyc();

        // Out-of-order writeback retires in program order.
        do_reset();
        set_issue(5'd1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
        set_issue(5'd2, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4); cyc();
        idle(); lsb_result = 1'b1; lsb_rob_pos = 4'd1; lsb_val = 32'hBB; cyc();
        idle(); alu_result = 1'b1; alu_rob_pos = 4'd0; alu_val = 32'hAA; cyc();
        idle(); cyc();
        chk("t3_first", commit_val, 32'hAA);
        cyc();
        chk("t3_second", commit_val, 32'hBB);
        chk("t3_store", 32'(commit_store), 32'd1);

        // Same-cycle query bypass.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(5'(i + 1), 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
        end
        idle(); rs1_rob_pos = 4'd3; alu_result = 1'b1; alu_rob_pos = 4'd3; alu_val = 32'hCAFE;
        #1;
        chk("t4_rs1_ready", 32'(rs1_ready), 32'd1);
        chk("t4_rs1_val", rs1_val, 32'hCAFE);
        cyc();

        // Mispredicted branch flushes younger entries.
        do_reset();
        set_issue(5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h100); cyc();
        set_issue(5'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h104); cyc();
        set_issue(5'd4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h108); cyc();
        idle(); alu_result = 1'b1; alu_rob_pos = 4'd0; alu_br_taken = 1'b1; alu_br_target = 32'h200;
        lsb_result = 1'b1; lsb_rob_pos = 4'd1; lsb_val = 32'h77; cyc();
        idle(); cyc();
        chk("t5_rollback", 32'(rollback), 32'd1);
        chk("t5_rollback_pc", rollback_pc, 32'h200);
        set_issue(5'd7, 1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 32'h200); cyc();
        idle();
        #1 chk("t5_next_pos", 32'(issue_rob_pos), 32'd0);
        for (int i = 0; i < 3; i++) cyc();

        // Three retirements plus one mispredict, then reset during the flush pulse.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(5'(i + 10), 1'b1, 1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 32'(i * 4)); cyc();
        end
        set_issue(5'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h40); cyc();
        idle(); cyc();
        chk("t6_rollback_pc", rollback_pc, 32'h44);
`ifdef ROB_PERF_EN
        chk("t6_perf_commit", perf_commit_cnt, 32'd4);
        chk("t6_perf_flush", perf_flush_cnt, 32'd1);
`endif
        #2 rst_n = 1'b0;
        #1 chk("t7_async_rollback", 32'(rollback), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            rs1_rob_pos = 4'($urandom); rs2_rob_pos = 4'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                logic br = ($urandom_range(0, 4) == 0);
                set_issue(5'($urandom), !br, ($urandom_range(0, 3) == 0), $urandom,
                          !br && ($urandom_range(0, 6) == 0), br, 1'($urandom), $urandom & 32'hFFFF_FFFC);
            end
            cand = {};
            foreach (q[i]) if (!q[i].ready) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, cand.size() - 1);
                alu_result = 1'b1; alu_rob_pos = 4'((head + cand[k]) % 16); alu_val = $urandom;
                alu_br_taken = 1'($urandom); alu_br_target = $urandom & 32'hFFFF_FFFC;
                cand.delete(k);
            end
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, cand.size() - 1);
                lsb_result = 1'b1; lsb_rob_pos = 4'((head + cand[k]) % 16); lsb_val = $urandom;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
